// File: rtl/mem_byte_bridge_pkg.sv
// mem_byte_bridge_pkg: size encodings, FSM states and small decode helpers
// shared by the byte bridge and its CPU-side interface.
package mem_byte_bridge_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Index of the last byte of a transfer (N-1); illegal sizes never transfer.
    function automatic logic [1:0] last_idx(size_e size);
        case (size)
            SIZE_HALF: return 2'd1;
            SIZE_WORD: return 2'd3;
            default:   return 2'd0;
        endcase
    endfunction

    // Half needs addr[0]==0, word needs addr[1:0]==0; bytes are always aligned.
    function automatic logic is_misaligned(size_e size, logic [1:0] addr_lo);
        case (size)
            SIZE_HALF: return addr_lo[0];
            SIZE_WORD: return addr_lo != 2'b00;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_bridge_if.sv
// mem_byte_bridge_if: CPU-side valid/ready request and one-cycle response port.
// The CPU side uses the master modport, the bridge the slave modport.
interface mem_byte_bridge_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_byte_bridge.sv
// mem_byte_bridge: serialises CPU byte/half/word requests into little-endian
// byte accesses on a byte-wide synchronous memory, and decodes an output
// register at and above IO_BASE.
// Build option: define MISALIGN_TRAP_EN to reject misaligned half/word
// requests with rsp_err instead of splitting them across the boundary.
module mem_byte_bridge
    import mem_byte_bridge_pkg::*;
#(
    parameter int                  ADDR_WIDTH = 32,
    // One bit wider than the address so the region can be placed above the
    // address space, which disables it.
    parameter logic [ADDR_WIDTH:0] IO_BASE    = (ADDR_WIDTH+1)'(32'hFFFF0000),
    parameter int                  IO_WIDTH   = 8,
    parameter logic [IO_WIDTH-1:0] IO_RESET   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_byte_bridge_if.slave      bus,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  mem_we,
    input  logic [7:0]            mem_rdata,
    output logic [IO_WIDTH-1:0]   io_out
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic                  we_q;
    logic [1:0]            last_q;
    logic [1:0]            k_q;
    logic [31:0]           rdata_q;
    logic                  err_q;
    logic [IO_WIDTH-1:0]   io_q;

    size_e req_size;
    logic  illegal, misaligned, err_req, io_hit, accept;

    // Decode the request presented on the bus; only used at the accept edge.
    always_comb begin
        req_size = size_e'(bus.req_size);
        illegal  = (req_size == SIZE_ILL);
`ifdef MISALIGN_TRAP_EN
        misaligned = is_misaligned(req_size, bus.req_addr[1:0]);
`else
        misaligned = 1'b0;
`endif
        err_req = illegal || misaligned;
        io_hit  = ({1'b0, bus.req_addr} >= IO_BASE);
        accept  = bus.req_valid && (state_q == ST_IDLE);
    end

    // State register; reset mid-transfer drops straight back to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic: IO and error requests skip the memory phases.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case statement can leave it unassigned (no latch).
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = (err_req || io_hit) ? ST_RESP : ST_XFER;
            end
            ST_XFER: begin
                if (k_q == last_q) state_d = we_q ? ST_RESP : ST_DRAIN;
            end
            ST_DRAIN: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Memory port and response outputs decoded from the current state.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (state_q == ST_XFER) begin
            mem_addr = addr_q + ADDR_WIDTH'(k_q);
            mem_we   = we_q;
            if (we_q) mem_wdata = wdata_q[{k_q, 3'b000} +: 8];
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = (state_q == ST_RESP) ? rdata_q : 32'd0;
    assign bus.rsp_err   = (state_q == ST_RESP) && err_q;
    assign io_out        = io_q;

    // Request latch, byte counter, read assembly and the output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            last_q  <= '0;
            k_q     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            io_q    <= IO_RESET;
        end else begin
            // NOTE: non-blocking assignments so every register here samples
            // the pre-edge values, independent of statement order.
            if (accept) begin
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                we_q    <= bus.req_we;
                last_q  <= last_idx(req_size);
                k_q     <= '0;
                err_q   <= err_req;
                rdata_q <= (io_hit && !err_req && !bus.req_we) ? 32'(io_q) : 32'd0;
                if (io_hit && !err_req && bus.req_we)
                    io_q <= bus.req_wdata[IO_WIDTH-1:0];
            end
            if (state_q == ST_XFER) begin
                k_q <= k_q + 2'd1;
                // Memory data lags the address by one cycle: byte k-1 arrives now.
                if (!we_q && (k_q != 2'd0))
                    rdata_q[{k_q - 2'd1, 3'b000} +: 8] <= mem_rdata;
            end
            if (state_q == ST_DRAIN)
                rdata_q[{last_q, 3'b000} +: 8] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_byte_bridge.sv
// tb_mem_byte_bridge: randomized and directed self-checking bench for the
// byte bridge, with a byte-addressed reference model of memory and io_out.
module tb_mem_byte_bridge;
    import mem_byte_bridge_pkg::*;

    localparam int         AW     = 32;
    localparam logic [7:0] IO_RST = 8'h5A;
    localparam logic [31:0] IO_LO = 32'hFFFF0000;

    typedef struct { logic [31:0] addr; logic [7:0] data; } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default IO region.
    mem_byte_bridge_if #(.ADDR_WIDTH(AW)) bus ();
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata, mem_rdata = 8'h00, io_out;
    logic          mem_we;

    mem_byte_bridge #(.ADDR_WIDTH(AW), .IO_BASE(33'h0_FFFF_0000), .IO_WIDTH(8), .IO_RESET(IO_RST)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata), .io_out(io_out));

    // Instance B: IO region above the address space, so all addresses are memory.
    mem_byte_bridge_if #(.ADDR_WIDTH(AW)) bus_w ();
    logic [AW-1:0] mem_addr_w;
    logic [7:0]    mem_wdata_w, mem_rdata_w = 8'h00, io_out_w;
    logic          mem_we_w;

    mem_byte_bridge #(.ADDR_WIDTH(AW), .IO_BASE(33'h1_0000_0000), .IO_WIDTH(8), .IO_RESET(IO_RST)) dut_w (
        .clk(clk), .rst(rst), .bus(bus_w.slave), .mem_addr(mem_addr_w), .mem_wdata(mem_wdata_w),
        .mem_we(mem_we_w), .mem_rdata(mem_rdata_w), .io_out(io_out_w));

    // Environment memories (synchronous read, one-cycle latency) with write logs.
    logic [7:0] mem_a [logic [31:0]];
    logic [7:0] mem_b [logic [31:0]];
    wr_t        log_a [$];
    wr_t        log_b [$];

    always @(posedge clk) begin
        mem_rdata <= mem_a.exists(mem_addr) ? mem_a[mem_addr] : 8'h00;
        if (mem_we) begin
            mem_a[mem_addr] = mem_wdata;
            log_a.push_back('{addr: mem_addr, data: mem_wdata});
        end
    end

    always @(posedge clk) begin
        mem_rdata_w <= mem_b.exists(mem_addr_w) ? mem_b[mem_addr_w] : 8'h00;
        if (mem_we_w) begin
            mem_b[mem_addr_w] = mem_wdata_w;
            log_b.push_back('{addr: mem_addr_w, data: mem_wdata_w});
        end
    end

    // Reference model: byte array plus output register value.
    logic [7:0] ref_mem [logic [31:0]];
    logic [7:0] ref_io = IO_RST;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [7:0] ref_rd(logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic logic [7:0] env_rd(logic [31:0] a);
        return mem_a.exists(a) ? mem_a[a] : 8'h00;
    endfunction

    // Issue one request on instance A and wait for its response.
    task automatic do_req(input logic we, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                          output logic err, output int nwr, output logic pulse_ok);
        int w0;
        int guard;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_size  = size;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        w0    = log_a.size();
        guard = 0;
        while (!bus.req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        @(posedge clk); #1;
        pulse_ok = !bus.rsp_valid && bus.req_ready;
        nwr = log_a.size() - w0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_checks++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b want 0", bus.rsp_err); end
        n_checks++; if (bus.rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h want 0", bus.rsp_rdata); end
        n_checks++; if ({mem_we, mem_addr, mem_wdata} !== 41'd0) begin n_fail++; $display("FAIL reset_mem_port: got we=%b addr=%h wdata=%h want 0", mem_we, mem_addr, mem_wdata); end
        n_checks++; if (io_out !== IO_RST) begin n_fail++; $display("FAIL reset_io_out: got %h want %h", io_out, IO_RST); end
        rst = 1'b1;
    endtask

    task automatic test_word();
        int lat, nwr; logic [31:0] rd; logic err, pok;
        do_req(1'b1, 2'b10, 32'h100, 32'h11223344, lat, rd, err, nwr, pok);
        for (int i = 0; i < 4; i++) ref_mem[32'h100 + i] = 8'(32'h11223344 >> (8 * i));
        n_checks++; if (lat != 5) begin n_fail++; $display("FAIL word_wr_latency: got %0d want 5", lat); end
        n_checks++; if (nwr != 4) begin n_fail++; $display("FAIL word_wr_count: got %0d want 4", nwr); end
        n_checks++; if ({env_rd(32'h100), env_rd(32'h101), env_rd(32'h102), env_rd(32'h103)} !== 32'h44332211)
            begin n_fail++; $display("FAIL word_wr_bytes: got %h%h%h%h want 44332211", env_rd(32'h100), env_rd(32'h101), env_rd(32'h102), env_rd(32'h103)); end
        n_checks++; if (rd !== 32'd0 || err !== 1'b0) begin n_fail++; $display("FAIL word_wr_rsp: got rdata=%h err=%b want 0/0", rd, err); end
        do_req(1'b0, 2'b10, 32'h100, 32'h0, lat, rd, err, nwr, pok);
        n_checks++; if (lat != 6) begin n_fail++; $display("FAIL word_rd_latency: got %0d want 6", lat); end
        n_checks++; if (rd !== 32'h11223344) begin n_fail++; $display("FAIL word_rd_data: got %h want 11223344", rd); end
        n_checks++; if (pok !== 1'b1) begin n_fail++; $display("FAIL word_rd_pulse: rsp_valid not a single-cycle pulse"); end
    endtask

    task automatic test_byte_read();
        int lat, nwr; logic [31:0] rd; logic err, pok;
        do_req(1'b0, 2'b00, 32'h102, 32'h0, lat, rd, err, nwr, pok);
        n_checks++; if (lat != 3) begin n_fail++; $display("FAIL byte_rd_latency: got %0d want 3", lat); end
        n_checks++; if (rd !== 32'h00000022) begin n_fail++; $display("FAIL byte_rd_data: got %h want 00000022", rd); end
    endtask

    task automatic test_io();
        int lat, nwr; logic [31:0] rd; logic err, pok;
        do_req(1'b1, 2'b10, IO_LO, 32'h123456A5, lat, rd, err, nwr, pok);
        ref_io = 8'hA5;
        n_checks++; if (io_out !== 8'hA5) begin n_fail++; $display("FAIL io_wr_value: got %h want a5", io_out); end
        n_checks++; if (lat != 1 || nwr != 0) begin n_fail++; $display("FAIL io_wr_timing: got lat=%0d writes=%0d want 1/0", lat, nwr); end
        do_req(1'b0, 2'b00, IO_LO, 32'h0, lat, rd, err, nwr, pok);
        n_checks++; if (rd !== 32'h000000A5 || err !== 1'b0) begin n_fail++; $display("FAIL io_rd_data: got %h err=%b want 000000a5/0", rd, err); end
        n_checks++; if (lat != 1 || nwr != 0) begin n_fail++; $display("FAIL io_rd_timing: got lat=%0d writes=%0d want 1/0", lat, nwr); end
        // Illegal size aimed at the IO region: error, no side effects.
        do_req(1'b1, 2'b11, IO_LO, 32'h0000003C, lat, rd, err, nwr, pok);
        n_checks++; if (err !== 1'b1 || lat != 1 || nwr != 0 || io_out !== 8'hA5)
            begin n_fail++; $display("FAIL illegal_size: got err=%b lat=%0d writes=%0d io=%h want 1/1/0/a5", err, lat, nwr, io_out); end
    endtask

    task automatic test_misalign();
        int lat, nwr; logic [31:0] rd; logic err, pok;
        do_req(1'b1, 2'b01, 32'h101, 32'h0000BEEF, lat, rd, err, nwr, pok);
`ifdef MISALIGN_TRAP_EN
        n_checks++; if (err !== 1'b1 || nwr != 0 || lat != 1)
            begin n_fail++; $display("FAIL misalign_trap: got err=%b writes=%0d lat=%0d want 1/0/1", err, nwr, lat); end
`else
        ref_mem[32'h101] = 8'hEF;
        ref_mem[32'h102] = 8'hBE;
        n_checks++; if (err !== 1'b0 || nwr != 2 || lat != 3)
            begin n_fail++; $display("FAIL misalign_split: got err=%b writes=%0d lat=%0d want 0/2/3", err, nwr, lat); end
        n_checks++; if (env_rd(32'h101) !== 8'hEF || env_rd(32'h102) !== 8'hBE)
            begin n_fail++; $display("FAIL misalign_bytes: got %h %h want ef be", env_rd(32'h101), env_rd(32'h102)); end
`endif
    endtask

    task automatic test_wrap();
        int lat;
        log_b.delete();
        @(posedge clk); #1;
        bus_w.req_valid = 1'b1;
        bus_w.req_we    = 1'b1;
        bus_w.req_size  = 2'b10;
        bus_w.req_addr  = 32'hFFFFFFFE;
        bus_w.req_wdata = 32'hDDCCBBAA;
        @(posedge clk); #1;
        bus_w.req_valid = 1'b0;
        lat = 1;
        while (!bus_w.rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        n_checks++; if (lat != 5 || bus_w.rsp_err !== 1'b0) begin n_fail++; $display("FAIL wrap_rsp: got lat=%0d err=%b want 5/0", lat, bus_w.rsp_err); end
        n_checks++; if (log_b.size() != 4) begin n_fail++; $display("FAIL wrap_count: got %0d want 4", log_b.size()); end
        for (int i = 0; i < 4 && i < log_b.size(); i++) begin
            logic [31:0] ea;
            logic [7:0]  ed;
            ea = 32'hFFFFFFFE + 32'(i);
            ed = 8'(32'hDDCCBBAA >> (8 * i));
            n_checks++; if (log_b[i].addr !== ea || log_b[i].data !== ed)
                begin n_fail++; $display("FAIL wrap_byte%0d: got %h@%h want %h@%h", i, log_b[i].data, log_b[i].addr, ed, ea); end
        end
    endtask

    task automatic test_reset_mid();
        int lat, nwr, w0; logic [31:0] rd; logic err, pok;
        @(posedge clk); #1;
        w0 = log_a.size();
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b10;
        bus.req_addr = 32'h180; bus.req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++; if (mem_we !== 1'b0 || bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0)
            begin n_fail++; $display("FAIL midreset_outputs: got we=%b ready=%b rsp=%b want 0/1/0", mem_we, bus.req_ready, bus.rsp_valid); end
        n_checks++; if (io_out !== IO_RST) begin n_fail++; $display("FAIL midreset_io: got %h want %h", io_out, IO_RST); end
        ref_io = IO_RST;
        ref_mem[32'h180] = 8'h0D;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        n_checks++; if (log_a.size() - w0 != 1) begin n_fail++; $display("FAIL midreset_writes: got %0d want 1", log_a.size() - w0); end
        do_req(1'b1, 2'b10, 32'h184, 32'h0BADBEEF, lat, rd, err, nwr, pok);
        for (int i = 0; i < 4; i++) ref_mem[32'h184 + i] = 8'(32'h0BADBEEF >> (8 * i));
        do_req(1'b0, 2'b10, 32'h184, 32'h0, lat, rd, err, nwr, pok);
        n_checks++; if (rd !== 32'h0BADBEEF || lat != 6) begin n_fail++; $display("FAIL midreset_recover: got %h lat=%0d want 0badbeef/6", rd, lat); end
    endtask

    task automatic test_random();
        int lat, nwr, n, exp_lat, exp_nwr;
        logic [31:0] rd, addr, wdata, exp_rd;
        logic err, pok, we, exp_err, mis;
        logic [1:0] size;
        for (int it = 0; it < 60; it++) begin
            we    = 1'($urandom % 2);
            size  = 2'($urandom % 4);
            wdata = $urandom;
            addr  = ($urandom % 8 == 0) ? (IO_LO | ($urandom & 32'h0000FFFF)) : (32'h200 + ($urandom % 32));
            n     = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : (size == 2'b10) ? 4 : 0;
            mis   = (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
`ifdef MISALIGN_TRAP_EN
            exp_err = (size == 2'b11) || mis;
`else
            exp_err = (size == 2'b11);
`endif
            exp_rd = 32'd0;
            if (exp_err) begin
                exp_lat = 1; exp_nwr = 0;
            end else if (addr >= IO_LO) begin
                exp_lat = 1; exp_nwr = 0;
                if (we) ref_io = wdata[7:0];
                else    exp_rd = {24'd0, ref_io};
            end else begin
                exp_lat = n + (we ? 1 : 2);
                exp_nwr = we ? n : 0;
                for (int i = 0; i < n; i++) begin
                    if (we) ref_mem[addr + 32'(i)] = wdata[8 * i +: 8];
                    else    exp_rd[8 * i +: 8] = ref_rd(addr + 32'(i));
                end
            end
            do_req(we, size, addr, wdata, lat, rd, err, nwr, pok);
            n_checks++; if (rd !== exp_rd || err !== exp_err || lat != exp_lat || nwr != exp_nwr || io_out !== ref_io || pok !== 1'b1)
                begin n_fail++; $display("FAIL random_%0d: we=%b size=%b addr=%h got rdata=%h err=%b lat=%0d wr=%0d io=%h want %h/%b/%0d/%0d/%h",
                                         it, we, size, addr, rd, err, lat, nwr, io_out, exp_rd, exp_err, exp_lat, exp_nwr, ref_io); end
        end
        for (int a = 32'h200; a < 32'h224; a++) begin
            n_checks++; if (env_rd(32'(a)) !== ref_rd(32'(a)))
                begin n_fail++; $display("FAIL random_mem_%h: got %h want %h", a, env_rd(32'(a)), ref_rd(32'(a))); end
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_addr = '0; bus.req_wdata = '0;
        bus_w.req_valid = 1'b0; bus_w.req_we = 1'b0; bus_w.req_size = 2'b00; bus_w.req_addr = '0; bus_w.req_wdata = '0;
        test_reset();
        test_word();
        test_byte_read();
        test_io();
        test_misalign();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
